// File: rtl/lpr_boundary_detect.sv
`default_nettype none
// ---------------------------------------------------------------------------
// lpr_boundary_detect : per-frame bounding box of rows with >= ROW_TH fg pixels
// Revision: 1.0
// ---------------------------------------------------------------------------
module lpr_boundary_detect #(
  parameter int ROW_TH = 8,
  parameter int MIN_W  = 16,
  parameter int MIN_H  = 8
) (
  input  logic        pixelclk,
  input  logic        reset_n,
  input  logic        i_bin,
  input  logic        i_hsync,
  input  logic        i_vsync,
  input  logic        i_de,
  input  logic [11:0] hcount,
  input  logic [11:0] vcount,
  output logic [11:0] hcount_l,
  output logic [11:0] hcount_r,
  output logic [11:0] vcount_l,
  output logic [11:0] vcount_r,
  output logic        o_valid,
  output logic        o_frame_done
);

  localparam logic [1:0]  S_IDLE   = 2'd0;
  localparam logic [1:0]  S_RUN    = 2'd1;
  localparam logic [1:0]  S_COMMIT = 2'd2;
  localparam logic [11:0] c_MAX    = 12'hFFF;

  logic        w_unused_hsync;
  assign w_unused_hsync = i_hsync;

  logic        de_q, vs_q;
  logic [1:0]  state_q, state_d;
  logic [11:0] line_cnt_q, line_cnt_d, line_min_q, line_min_d, line_max_q, line_max_d;
  logic [11:0] row_q, row_d;
  logic [11:0] hmin_q, hmin_d, hmax_q, hmax_d, vmin_q, vmin_d, vmax_q, vmax_d;
  logic        hit_q, hit_d;
  logic [11:0] hl_q, hr_q, vl_q, vr_q;
  logic        valid_q, done_q;

  logic w_line_end, w_frame_end, w_commit, w_merge_en, w_row_hit, w_box_ok;

  assign w_line_end  = de_q & ~i_de;
  assign w_frame_end = ~vs_q & i_vsync;
  assign w_row_hit   = (line_cnt_q >= 12'(ROW_TH));

  // FSM: state register
  always_ff @(posedge pixelclk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (w_frame_end) state_d = S_RUN;
      S_RUN:    if (w_frame_end) state_d = S_COMMIT;
      S_COMMIT: state_d = S_RUN;
      default:  state_d = S_IDLE;
    endcase
  end

  // FSM: decoded controls
  always_comb begin
    w_commit   = (state_q == S_COMMIT);
    w_merge_en = (state_q != S_IDLE);
  end

  always_comb begin
    line_cnt_d = line_cnt_q;
    line_min_d = line_min_q;
    line_max_d = line_max_q;
    row_d      = row_q;
    if (w_line_end) begin
      line_cnt_d = '0;
      line_min_d = c_MAX;
      line_max_d = '0;
    end else if (i_de) begin
      row_d = vcount;
      if (i_bin) begin
        if (line_cnt_q != c_MAX) line_cnt_d = line_cnt_q + 12'd1;
        if (hcount < line_min_q) line_min_d = hcount;
        if (hcount > line_max_q) line_max_d = hcount;
      end
    end
  end

  // A line ending during COMMIT belongs to the new frame, so merge onto cleared values.
  always_comb begin
    if (w_commit) begin
      hmin_d = c_MAX;
      hmax_d = '0;
      vmin_d = c_MAX;
      vmax_d = '0;
      hit_d  = 1'b0;
    end else begin
      hmin_d = hmin_q;
      hmax_d = hmax_q;
      vmin_d = vmin_q;
      vmax_d = vmax_q;
      hit_d  = hit_q;
    end
    if (w_line_end && w_merge_en && w_row_hit) begin
      hit_d = 1'b1;
      if (row_q < vmin_d) vmin_d = row_q;
      if (row_q > vmax_d) vmax_d = row_q;
      if (line_min_q <= line_max_q) begin
        if (line_min_q < hmin_d) hmin_d = line_min_q;
        if (line_max_q > hmax_d) hmax_d = line_max_q;
      end
    end
  end

  // Compare as max+1 >= min+MIN so an empty span can never look large.
  assign w_box_ok = hit_q
                  & (({2'b00, hmax_q} + 14'd1) >= ({2'b00, hmin_q} + 14'(MIN_W)))
                  & (({2'b00, vmax_q} + 14'd1) >= ({2'b00, vmin_q} + 14'(MIN_H)));

  always_ff @(posedge pixelclk or negedge reset_n) begin
    if (!reset_n) begin
      de_q       <= 1'b0;
      vs_q       <= 1'b0;
      line_cnt_q <= '0;
      line_min_q <= c_MAX;
      line_max_q <= '0;
      row_q      <= '0;
      hmin_q     <= c_MAX;
      hmax_q     <= '0;
      vmin_q     <= c_MAX;
      vmax_q     <= '0;
      hit_q      <= 1'b0;
      hl_q       <= '0;
      hr_q       <= '0;
      vl_q       <= '0;
      vr_q       <= '0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      de_q       <= i_de;
      vs_q       <= i_vsync;
      line_cnt_q <= line_cnt_d;
      line_min_q <= line_min_d;
      line_max_q <= line_max_d;
      row_q      <= row_d;
      hmin_q     <= hmin_d;
      hmax_q     <= hmax_d;
      vmin_q     <= vmin_d;
      vmax_q     <= vmax_d;
      hit_q      <= hit_d;
      done_q     <= w_commit;
      if (w_commit) begin
        valid_q <= w_box_ok;
        hl_q    <= w_box_ok ? hmin_q : 12'd0;
        hr_q    <= w_box_ok ? hmax_q : 12'd0;
        vl_q    <= w_box_ok ? vmin_q : 12'd0;
        vr_q    <= w_box_ok ? vmax_q : 12'd0;
      end
    end
  end

  assign hcount_l     = hl_q;
  assign hcount_r     = hr_q;
  assign vcount_l     = vl_q;
  assign vcount_r     = vr_q;
  assign o_valid      = valid_q;
  assign o_frame_done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_lpr_boundary_detect.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_lpr_boundary_detect : scoreboard bench for the frame bounding-box detector
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_lpr_boundary_detect;

  localparam int c_ROW_TH = 8;
  localparam int c_MIN_W  = 16;
  localparam int c_MIN_H  = 8;

  logic        pixelclk = 1'b0;
  logic        reset_n  = 1'b0;
  logic        i_bin = 1'b0, i_hsync = 1'b0, i_vsync = 1'b0, i_de = 1'b0;
  logic [11:0] hcount = '0, vcount = '0;
  logic [11:0] hcount_l, hcount_r, vcount_l, vcount_r;
  logic        o_valid, o_frame_done;

  lpr_boundary_detect #(.ROW_TH(c_ROW_TH), .MIN_W(c_MIN_W), .MIN_H(c_MIN_H)) u_dut (
    .pixelclk(pixelclk), .reset_n(reset_n), .i_bin(i_bin), .i_hsync(i_hsync),
    .i_vsync(i_vsync), .i_de(i_de), .hcount(hcount), .vcount(vcount),
    .hcount_l(hcount_l), .hcount_r(hcount_r), .vcount_l(vcount_l), .vcount_r(vcount_r),
    .o_valid(o_valid), .o_frame_done(o_frame_done)
  );

  always #5 pixelclk = ~pixelclk;

  typedef struct {
    int          cyc;
    logic        v;
    logic [11:0] hl, hr, vl, vr;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0, n_fail = 0;
  int   cyc = 0, n_pushed = 0, n_seen = 0;
  bit   done_prev = 1'b0;

  int m_hmin, m_hmax, m_vmin, m_vmax;
  bit m_hit, armed;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  always @(posedge pixelclk) cyc <= cyc + 1;

  always @(negedge pixelclk) begin
    if (o_frame_done) begin
      check_val("done_width", done_prev, 0);
      if (sb.size() == 0) begin
        check_val("unexpected_done", o_frame_done, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        n_seen++;
        check_val("latency",  cyc, e.cyc);
        check_val("o_valid",  o_valid, e.v);
        check_val("hcount_l", hcount_l, e.hl);
        check_val("hcount_r", hcount_r, e.hr);
        check_val("vcount_l", vcount_l, e.vl);
        check_val("vcount_r", vcount_r, e.vr);
      end
    end
    done_prev = o_frame_done;
  end

  task automatic model_clear();
    m_hmin = 4095; m_hmax = 0; m_vmin = 4095; m_vmax = 0; m_hit = 1'b0;
  endtask

  task automatic step();
    @(posedge pixelclk);
    #1;
  endtask

  // Active window c0..c1 on one row, foreground on f0..f1 (f0 > f1 means none).
  task automatic drive_line(input int row, input int c0, input int c1, input int f0, input int f1);
    int lo, hi, cnt;
    for (int h = c0; h <= c1; h++) begin
      step();
      i_de   = 1'b1;
      hcount = 12'(h);
      vcount = 12'(row);
      i_bin  = (h >= f0 && h <= f1);
    end
    lo  = (f0 > c0) ? f0 : c0;
    hi  = (f1 < c1) ? f1 : c1;
    cnt = (hi >= lo) ? hi - lo + 1 : 0;
    if (armed && cnt >= c_ROW_TH) begin
      m_hit = 1'b1;
      if (row < m_vmin) m_vmin = row;
      if (row > m_vmax) m_vmax = row;
      if (cnt > 0) begin
        if (lo < m_hmin) m_hmin = lo;
        if (hi > m_hmax) m_hmax = hi;
      end
    end
  endtask

  task automatic blank(input int n);
    repeat (n) begin
      step();
      i_de  = 1'b0;
      i_bin = 1'b0;
    end
  endtask

  task automatic rect(input int r0, input int r1, input int f0, input int f1);
    for (int r = r0; r <= r1; r++) begin
      drive_line(r, f0 - 2, f1 + 2, f0, f1);
      blank(1);
    end
  endtask

  task automatic vsync_pulse();
    exp_t e;
    bit   ok;
    step();
    i_de    = 1'b0;
    i_bin   = 1'b0;
    i_vsync = 1'b1;
    if (armed) begin
      ok = m_hit && (m_hmax + 1 >= m_hmin + c_MIN_W) && (m_vmax + 1 >= m_vmin + c_MIN_H);
      e.cyc = cyc + 2;
      e.v   = ok;
      e.hl  = ok ? 12'(m_hmin) : 12'd0;
      e.hr  = ok ? 12'(m_hmax) : 12'd0;
      e.vl  = ok ? 12'(m_vmin) : 12'd0;
      e.vr  = ok ? 12'(m_vmax) : 12'd0;
      sb.push_back(e);
      n_pushed++;
    end
    armed = 1'b1;
    model_clear();
    repeat (3) step();
    i_vsync = 1'b0;
    blank(4);
  endtask

  initial begin
    #950000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    armed = 1'b0;
    model_clear();
    repeat (3) @(negedge pixelclk);
    check_val("rst_hcount_l", hcount_l, 0);
    check_val("rst_hcount_r", hcount_r, 0);
    check_val("rst_vcount_l", vcount_l, 0);
    check_val("rst_vcount_r", vcount_r, 0);
    check_val("rst_valid", o_valid, 0);
    check_val("rst_done", o_frame_done, 0);
    step();
    reset_n = 1'b1;
    blank(3);

    // Arm, then one valid frame so the mid-frame reset has something to clear.
    vsync_pulse();
    rect(200, 209, 100, 299);
    vsync_pulse();
    blank(5);

    rect(200, 205, 100, 299);
    step();
    reset_n = 1'b0;
    armed   = 1'b0;
    model_clear();
    #1;
    check_val("async_rst_valid", o_valid, 0);
    check_val("async_rst_hcount_r", hcount_r, 0);
    step();
    reset_n = 1'b1;
    rect(200, 209, 100, 299);
    vsync_pulse();
    blank(6);
    check_val("first_frame_valid", o_valid, 0);
    check_val("first_frame_vcount_r", vcount_r, 0);

    // Solid rectangle
    rect(200, 259, 100, 299);
    vsync_pulse();

    // Row 50 with 7 pixels: ignored
    drive_line(50, 100, 310, 120, 126); blank(1);
    rect(200, 259, 100, 299);
    vsync_pulse();

    // Row 50 with 8 pixels: counted
    drive_line(50, 100, 310, 120, 127); blank(1);
    rect(200, 259, 100, 299);
    vsync_pulse();

    // Too small (width 11)
    rect(10, 40, 10, 20);
    vsync_pulse();

    // Width boundary: 16 valid, 15 invalid; height exactly 8
    rect(300, 307, 100, 115);
    vsync_pulse();
    rect(300, 307, 100, 114);
    vsync_pulse();

    // Valid then empty frame
    rect(200, 259, 100, 299);
    vsync_pulse();
    vsync_pulse();

    // Last line's de fall coincides with vsync rise
    rect(470, 478, 100, 299);
    drive_line(479, 98, 301, 100, 299);
    vsync_pulse();

    for (int i = 0; i < 50 && sb.size() != 0; i++) step();
    check_val("sb_drained", sb.size(), 0);
    check_val("frames_seen", n_seen, n_pushed);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
